// File: rtl/board_operand_loader.sv
// board_operand_loader: synchronises and debounces the board buttons and switches, then loads the shift-unit operands on debounced presses.
// Optional feature macro: LOADER_CLEAR_EN (swb[2] clears all operands).  Rev 1.0
`default_nettype none

module board_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sw,
    input  logic [5:0]  swb,
    output logic [31:0] shift_data,
    output logic [7:0]  shift_num,
    output logic [2:0]  shift_op,
    output logic        carry_flag,
    output logic        upd,
    output logic [3:0]  upd_src,
    output logic [5:0]  btn_state
);

    localparam logic [1:0] c_st_rel  = 2'd0;
    localparam logic [1:0] c_st_pchk = 2'd1;
    localparam logic [1:0] c_st_held = 2'd2;
    localparam logic [1:0] c_st_rchk = 2'd3;

    // Level changes are accepted on the DEBOUNCE_CYCLES-th consecutive sample,
    // counting the sample that left the stable state.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [5:0]  swb_s1_q;
    logic [5:0]  swb_s2_q;
    logic [31:0] sw_s1_q;
    logic [31:0] sw_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swb_s1_q <= '0;
            swb_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            swb_s1_q <= swb;
            swb_s2_q <= swb_s1_q;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    logic [5:0] w_press;

    for (genvar i = 0; i < 6; i++) begin : g_btn
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             lvl;

        assign lvl = swb_s2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            case (state_q)
                c_st_rel: begin
                    if (lvl) begin
                        cnt_d   = '0;
                        state_d = c_st_pchk;
                    end
                end
                c_st_pchk: begin
                    if (!lvl) begin
                        state_d = c_st_rel;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                        if (cnt_q == c_cnt_last) begin
                            state_d = c_st_held;
                            press_d = 1'b1;
                        end
                    end
                end
                c_st_held: begin
                    if (!lvl) begin
                        cnt_d   = '0;
                        state_d = c_st_rchk;
                    end
                end
                default: begin
                    if (lvl) begin
                        state_d = c_st_held;
                    end else begin
                        cnt_d = cnt_q + c_cnt_one;
                        if (cnt_q == c_cnt_last) begin
                            state_d = c_st_rel;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= c_st_rel;
                cnt_q   <= '0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                press_q <= press_d;
            end
        end

        assign w_press[i]   = press_q;
        assign btn_state[i] = (state_q == c_st_held) || (state_q == c_st_rchk);
    end

    logic [31:0] shift_data_q, shift_data_d;
    logic [7:0]  shift_num_q,  shift_num_d;
    logic [2:0]  shift_op_q,   shift_op_d;
    logic        carry_flag_q, carry_flag_d;
    logic        upd_q,        upd_d;
    logic [3:0]  upd_src_q,    upd_src_d;
    logic [3:0]  w_src;

`ifdef LOADER_CLEAR_EN
    assign w_src = {w_press[2], w_press[5], w_press[1], w_press[0]};
    logic unused_press;
    assign unused_press = ^w_press[4:3];
`else
    assign w_src = {1'b0, w_press[5], w_press[1], w_press[0]};
    logic unused_press;
    assign unused_press = ^w_press[4:2];
`endif

    always_comb begin
        shift_data_d = shift_data_q;
        shift_num_d  = shift_num_q;
        shift_op_d   = shift_op_q;
        carry_flag_d = carry_flag_q;
        if (w_src[0]) begin
            shift_data_d = sw_s2_q;
        end
        if (w_src[1]) begin
            shift_num_d = sw_s2_q[31:24];
            shift_op_d  = sw_s2_q[23:21];
        end
        if (w_src[2]) begin
            carry_flag_d = ~carry_flag_q;
        end
        // Clear wins over every other simultaneous load.
        if (w_src[3]) begin
            shift_data_d = '0;
            shift_num_d  = '0;
            shift_op_d   = '0;
            carry_flag_d = 1'b0;
        end
        upd_d     = |w_src;
        upd_src_d = w_src;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_data_q <= '0;
            shift_num_q  <= '0;
            shift_op_q   <= '0;
            carry_flag_q <= 1'b0;
            upd_q        <= 1'b0;
            upd_src_q    <= '0;
        end else begin
            shift_data_q <= shift_data_d;
            shift_num_q  <= shift_num_d;
            shift_op_q   <= shift_op_d;
            carry_flag_q <= carry_flag_d;
            upd_q        <= upd_d;
            upd_src_q    <= upd_src_d;
        end
    end

    assign shift_data = shift_data_q;
    assign shift_num  = shift_num_q;
    assign shift_op   = shift_op_q;
    assign carry_flag = carry_flag_q;
    assign upd        = upd_q;
    assign upd_src    = upd_src_q;

endmodule

`default_nettype wire

// File: tb/tb_board_operand_loader.sv
// tb_board_operand_loader: directed scenarios plus randomized buttons/switches checked against a run-length debounce model.
// Rev 1.0
`default_nettype none

module tb_board_operand_loader;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic [31:0] sw;
    logic [5:0]  swb;
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic        carry_flag;
    logic        upd;
    logic [3:0]  upd_src;
    logic [5:0]  btn_state;

    board_operand_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .swb       (swb),
        .shift_data(shift_data),
        .shift_num (shift_num),
        .shift_op  (shift_op),
        .carry_flag(carry_flag),
        .upd       (upd),
        .upd_src   (upd_src),
        .btn_state (btn_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: two-sample input delay, then a level is accepted once DEB
    // consecutive samples disagree with the current debounced level.
    logic [5:0]  m_s1, m_s2, m_deb, m_ev, m_evn;
    logic [31:0] m_sw1, m_sw2;
    int          m_run [6];
    logic [31:0] m_data;
    logic [7:0]  m_num;
    logic [2:0]  m_op;
    logic        m_carry, m_upd;
    logic [3:0]  m_src;
    logic        m_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_ev = '0;
            m_sw1 = '0; m_sw2 = '0;
            for (int b = 0; b < 6; b++) m_run[b] = 0;
            m_data = '0; m_num = '0; m_op = '0; m_carry = 1'b0;
            m_upd = 1'b0; m_src = '0;
        end else begin
`ifdef LOADER_CLEAR_EN
            m_clr = m_ev[2];
`else
            m_clr = 1'b0;
`endif
            m_src = {m_clr, m_ev[5], m_ev[1], m_ev[0]};
            m_upd = (m_src != 4'd0);
            if (m_ev[0]) m_data = m_sw2;
            if (m_ev[1]) begin
                m_num = m_sw2[31:24];
                m_op  = m_sw2[23:21];
            end
            if (m_ev[5]) m_carry = !m_carry;
            if (m_clr) begin
                m_data = '0; m_num = '0; m_op = '0; m_carry = 1'b0;
            end
            m_evn = '0;
            for (int b = 0; b < 6; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_deb[b] = !m_deb[b];
                        m_run[b] = 0;
                        m_evn[b] = m_deb[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_ev  = m_evn;
            m_s2  = m_s1;
            m_s1  = swb;
            m_sw2 = m_sw1;
            m_sw1 = sw;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("m_data", shift_data, m_data);
            check_eq("m_num",  {24'd0, shift_num}, {24'd0, m_num});
            check_eq("m_op",   {29'd0, shift_op}, {29'd0, m_op});
            check_eq("m_carry", {31'd0, carry_flag}, {31'd0, m_carry});
            check_eq("m_upd",  {31'd0, upd}, {31'd0, m_upd});
            check_eq("m_src",  {28'd0, upd_src}, {28'd0, m_src});
            check_eq("m_btn",  {26'd0, btn_state}, {26'd0, m_deb});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the current inputs for n edges, checks upd timing relative to the first edge,
    // and returns the upd_src seen on the pulse and the number of pulses.
    task automatic watch(input int n, input int exp_edge, input string tag,
                         output logic [3:0] src, output int pulses);
        src = '0;
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (exp_edge >= 0) check_eq(tag, {31'd0, upd}, {31'd0, (k == exp_edge)});
            if (upd) begin
                pulses++;
                src = upd_src;
            end
        end
    endtask

    logic [3:0] src;
    int         pulses;
    int         hold_left [6];

    initial begin
        rst = 1'b1;
        sw  = '0;
        swb = '0;
        idle(3);
        check_eq("rst_data", shift_data, 32'd0);
        check_eq("rst_misc", {shift_num, shift_op, carry_flag, upd, upd_src, btn_state},
                 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Data load: upd exactly at edge DEB+2 and no repeat while held.
        sw  = 32'hDEADBEEF;
        swb = 6'b000001;
        watch(12, DEB + 2, "dl_upd", src, pulses);
        check_eq("dl_data", shift_data, 32'hDEADBEEF);
        check_eq("dl_src", {28'd0, src}, 32'h1);
        check_eq("dl_pulses", pulses, 1);
        swb = '0;
        idle(10);

        // Bounce rejection on swb[1].
        swb[1] = 1'b1; idle(1);
        swb[1] = 1'b0; idle(1);
        swb[1] = 1'b1; idle(1);
        swb[1] = 1'b0;
        watch(12, -1, "", src, pulses);
        check_eq("bnc_pulses", pulses, 0);
        check_eq("bnc_btn", {31'd0, btn_state[1]}, 32'd0);
        check_eq("bnc_num", {24'd0, shift_num}, 32'd0);

        // Num/op load.
        sw  = {8'd5, 3'b010, 21'h0};
        swb = 6'b000010;
        watch(10, DEB + 2, "no_upd", src, pulses);
        check_eq("no_num", {24'd0, shift_num}, 32'd5);
        check_eq("no_op", {29'd0, shift_op}, 32'd2);
        check_eq("no_src", {28'd0, src}, 32'h2);
        swb = '0;
        idle(10);

        // Carry toggle twice.
        swb = 6'b100000;
        watch(8, DEB + 2, "cy1_upd", src, pulses);
        check_eq("cy1_carry", {31'd0, carry_flag}, 32'd1);
        swb = '0;
        idle(12);
        swb = 6'b100000;
        watch(8, DEB + 2, "cy2_upd", src, pulses);
        check_eq("cy2_carry", {31'd0, carry_flag}, 32'd0);
        check_eq("cy2_src", {28'd0, src}, 32'h4);
        swb = '0;
        idle(10);

        // Clear override: set up data=0x1234 and carry=1, then press 0,2,5 together.
        sw  = 32'h0000_1234;
        swb = 6'b100001;
        watch(8, -1, "", src, pulses);
        swb = '0;
        idle(10);
        check_eq("clr_setup_data", shift_data, 32'h1234);
        check_eq("clr_setup_carry", {31'd0, carry_flag}, 32'd1);
        sw  = 32'hFFFF_FFFF;
        swb = 6'b100101;
        watch(8, DEB + 2, "clr_upd", src, pulses);
`ifdef LOADER_CLEAR_EN
        check_eq("clr_data", shift_data, 32'd0);
        check_eq("clr_numop", {24'd0, shift_num, shift_op}, 32'd0);
        check_eq("clr_src", {28'd0, src}, 32'hD);
`else
        check_eq("clr_data", shift_data, 32'hFFFF_FFFF);
        check_eq("clr_numop", {21'd0, shift_num, shift_op}, {21'd0, 8'd5, 3'b010});
        check_eq("clr_src", {28'd0, src}, 32'h5);
`endif
        check_eq("clr_carry", {31'd0, carry_flag}, 32'd0);
        swb = '0;
        idle(10);

        // Reset at edge 3 of a held press, then a fresh full debounce.
        sw  = 32'hCAFE_F00D;
        swb = 6'b000001;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rmd_data", shift_data, 32'd0);
        check_eq("rmd_misc", {shift_num, shift_op, carry_flag, upd, upd_src, btn_state},
                 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watch(10, DEB + 2, "rmd_upd", src, pulses);
        check_eq("rmd_load", shift_data, 32'hCAFE_F00D);
        swb = '0;
        idle(10);

        // Randomized buttons, switches and occasional resets against the model.
        for (int b = 0; b < 6; b++) hold_left[b] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 6; b++) begin
                if (hold_left[b] == 0) begin
                    swb[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                                : int'($urandom_range(4, 14)));
                end else begin
                    hold_left[b]--;
                end
            end
            if ($urandom_range(0, 3) == 0) sw = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 check_eq("rnd_rst", {shift_data[7:0], shift_num, upd_src, carry_flag, upd,
                                        btn_state}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        swb = '0;
        idle(12);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
